// File: rtl/ps2_scancode_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_scancode_rx
//  Brief    : PS/2 keyboard receiver. Synchronizes and deglitches the PS/2
//             clock, deframes 11-bit frames (start, 8 data LSB first, odd
//             parity, stop) and decodes E0/F0 prefixes into make-code strobes
//             and break-sequence release pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_scancode_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] scancode,
  output logic       strobe,
  output logic       extended,
  output logic       released,
  output logic       frame_err
);

  // Counter widths; the filter counter needs to reach FILTER_LEN-1 and the
  // timeout counter TIMEOUT-1.
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  localparam logic [7:0] BYTE_EXT = 8'hE0;
  localparam logic [7:0] BYTE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Synchronizer and filter state
  logic          clk_meta_q, clk_meta_d;
  logic          clk_sync_q, clk_sync_d;
  logic          dat_meta_q, dat_meta_d;
  logic          dat_sync_q, dat_sync_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          filt_clk_q, filt_clk_d;

  // Frame receiver state
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_err_q, par_err_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;

  // Registered outputs
  logic [7:0]    scancode_q, scancode_d;
  logic          extended_q, extended_d;
  logic          strobe_q, strobe_d;
  logic          released_q, released_d;
  logic          frame_err_q, frame_err_d;

  logic          fall;
  logic          timeout_hit;

  // Two-flop synchronizers for both PS/2 lines
  always_comb begin
    clk_meta_d = PS2_CLK;
    clk_sync_d = clk_meta_q;
    dat_meta_d = PS2_DATA;
    dat_sync_d = dat_meta_q;
  end

  // Glitch filter: the filtered clock follows the synchronized clock only
  // after FILTER_LEN consecutive samples at the new level.
  always_comb begin
    filt_cnt_d = '0;
    filt_clk_d = filt_clk_q;
    if (clk_sync_q != filt_clk_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_clk_d = clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // A bit is taken in the very cycle the filtered clock flips from 1 to 0.
  assign fall        = filt_clk_q & ~filt_clk_d;
  assign timeout_hit = (state_q != ST_IDLE) && !fall && (to_cnt_q == TO_LAST);

  // Inactivity counter: only runs mid-frame, restarts on every falling edge.
  always_comb begin
    to_cnt_d = to_cnt_q + 1'b1;
    if (state_q == ST_IDLE || fall || timeout_hit) begin
      to_cnt_d = '0;
    end
  end

  // Frame deframing, prefix tracking and output pulse generation
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    scancode_d  = scancode_q;
    extended_d  = extended_q;
    strobe_d    = 1'b0;
    released_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          if (!dat_sync_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
            par_err_d = 1'b0;
          end else begin
            // Start bit must be 0; a high start is a framing error.
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
          end
        end
      end

      ST_DATA: begin
        if (fall) begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
      end

      ST_PARITY: begin
        if (fall) begin
          // Odd parity: data bits plus parity bit must hold an odd count of 1s.
          par_err_d = ~(^shift_q ^ dat_sync_q);
          state_d   = ST_STOP;
        end
      end

      ST_STOP: begin
        if (fall) begin
          // Back to IDLE immediately so a start bit right behind is not missed.
          state_d = ST_IDLE;
          if (!dat_sync_q || par_err_q) begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
          end else if (shift_q == BYTE_EXT) begin
            ext_pend_d = 1'b1;
          end else if (shift_q == BYTE_BRK) begin
            brk_pend_d = 1'b1;
          end else if (brk_pend_q) begin
            // Break code: report the release but keep the last make code.
            released_d = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
          end else begin
            scancode_d = shift_q;
            extended_d = ext_pend_q;
            strobe_d   = 1'b1;
            ext_pend_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A stalled keyboard clock abandons the frame and any pending prefix.
    if (timeout_hit) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      ext_pend_d  = 1'b0;
      brk_pend_d  = 1'b0;
    end
  end

  // State register with asynchronous reset; lines idle high on reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      dat_meta_q  <= 1'b1;
      dat_sync_q  <= 1'b1;
      filt_cnt_q  <= '0;
      filt_clk_q  <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_err_q   <= 1'b0;
      to_cnt_q    <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      scancode_q  <= 8'h00;
      extended_q  <= 1'b0;
      strobe_q    <= 1'b0;
      released_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      dat_meta_q  <= dat_meta_d;
      dat_sync_q  <= dat_sync_d;
      filt_cnt_q  <= filt_cnt_d;
      filt_clk_q  <= filt_clk_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      to_cnt_q    <= to_cnt_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      scancode_q  <= scancode_d;
      extended_q  <= extended_d;
      strobe_q    <= strobe_d;
      released_q  <= released_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign scancode  = scancode_q;
  assign extended  = extended_q;
  assign strobe    = strobe_q;
  assign released  = released_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: doc/ps2_scancode_rx.md
PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical CLK samples required to accept a new PS2_CLK level.
REQ-002 Parameter TIMEOUT, default 50000: CLK cycles without a PS2_CLK falling edge before an in-progress frame is aborted (1 ms at 50 MHz).
REQ-003 CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 RESET  input  1  reset, asynchronous, active-high.
REQ-005 PS2_CLK  input  1  keyboard clock, asynchronous to CLK, idle high.
REQ-006 PS2_DATA  input  1  keyboard data, asynchronous to CLK, idle high.
REQ-007 scancode  output  8  last accepted make code, held until the next make code.
REQ-008 strobe  output  1  one-CLK pulse when scancode is updated.
REQ-009 extended  output  1  set when the last accepted make code was E0-prefixed; held with scancode.
REQ-010 released  output  1  one-CLK pulse when a break sequence (F0 xx or E0 F0 xx) completes.
REQ-011 frame_err  output  1  one-CLK pulse on start, parity, stop or timeout error.

Function
REQ-012 PS2_CLK and PS2_DATA SHALL each pass a 2-flop synchronizer; PS2_CLK SHALL then pass a FILTER_LEN glitch filter.
REQ-013 A bit SHALL be sampled from synchronized PS2_DATA on the CLK cycle in which the filtered PS2_CLK falls 1->0.
REQ-014 Frame states: IDLE, DATA, PARITY, STOP; frame format: start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-015 IDLE: on a falling edge with data 0, go to DATA with bit count 0; with data 1, raise frame_err and stay in IDLE.
REQ-016 DATA: shift in one bit per falling edge; after the 8th bit, go to PARITY.
REQ-017 PARITY: sample the parity bit; if the XOR of the 8 data bits and the parity bit is 0, latch the parity error; go to STOP.
REQ-018 STOP: sample the stop bit; if it is 0 or a parity error is latched, raise frame_err and discard the byte; otherwise deliver the byte; return to IDLE.
REQ-019 Timeout: in DATA, PARITY or STOP, TIMEOUT cycles without a falling edge SHALL raise frame_err, clear the prefix flags and return to IDLE.
REQ-020 Delivered byte E0 SHALL set ext_pending; no outputs change.
REQ-021 Delivered byte F0 SHALL set brk_pending; no outputs change.
REQ-022 Any other byte with brk_pending=1 SHALL pulse released, leave scancode and extended unchanged, and clear both prefix flags.
REQ-023 Any other byte with brk_pending=0 SHALL load scancode, load extended from ext_pending, pulse strobe, and clear ext_pending.
REQ-024 strobe and released SHALL assert one CLK cycle after the stop-bit falling edge is detected.
REQ-025 Typematic repeats of the same make code SHALL pulse strobe each time.
REQ-026 frame_err SHALL clear both prefix flags.
REQ-027 A new start bit arriving in the same cycle as delivery SHALL NOT be lost; IDLE SHALL be entered the cycle the stop bit is sampled.

Reset
REQ-028 On RESET, asynchronously: scancode=00, strobe=0, extended=0, released=0, frame_err=0, state=IDLE, bit count=0, both prefix flags=0, timeout counter=0, synchronizers and filter=1.
REQ-029 Asserting RESET mid-frame SHALL drop the partial byte; after release, reception SHALL resume with the next start bit.

Verification
V-1 Frame 0x1B (parity bit 1, stop 1) -> scancode=1B, extended=0, strobe high exactly one cycle.
V-2 Frames E0, 75 -> scancode=75, extended=1, one strobe pulse; no strobe after E0 alone.
V-3 Frames 1B, F0, 1B -> one strobe pulse, then one released pulse; scancode stays 1B.
V-4 Frame 0x76 with a wrong parity bit -> frame_err pulse, scancode unchanged, no strobe; the next valid 0x76 strobes.
V-5 Stop PS2_CLK after 4 data bits for more than TIMEOUT cycles -> frame_err pulse; the following valid 0x4D frame yields scancode=4D.
V-6 A 3-CLK low glitch on PS2_CLK (less than FILTER_LEN) -> no bit sampled; RESET mid-frame -> all outputs at reset values.
